// File: rtl/example_pkg.sv
// Shared definitions for the example design: clock rate, the debounce FSM
// state encoding and a helper that turns milliseconds into clock cycles.
package example_pkg;

  localparam int CLOCK_HZ = 12_000_000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounce_state_t;

  // Number of design-clock cycles in ms milliseconds.
  function automatic int debounce_cycles(input int ms);
    return CLOCK_HZ / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchronizer, stability-counter debounce FSM and
// registered level/press/release outputs.
module button_debounce_chan
  import example_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic               IDLE_PIN = ACTIVE_LOW;

  // A one-cycle qualification window cannot be expressed by the WAIT states.
  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $fatal(1, "button_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic            sync_1, sync_2;
  logic            act;
  debounce_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic            press_evt, press_evt_d;
  logic            release_evt, release_evt_d;
  logic            pressed_d, press_d, release_d;

  // Two-flop synchronizer for the asynchronous pin.
  // NOTE: reset loads the released pin level, so a button already held at
  // reset release is seen as a fresh edge and must qualify from scratch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= IDLE_PIN;
      sync_2 <= IDLE_PIN;
    end else begin
      // NOTE: non-blocking assignments so sync_2 takes the old sync_1 value;
      // blocking here would collapse the two flops into one.
      sync_1 <= pin;
      sync_2 <= sync_1;
    end
  end

  assign act = sync_2 ^ ACTIVE_LOW;

  // State register: FSM state, stability counter and one-shot event flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      press_evt   <= press_evt_d;
      release_evt <= release_evt_d;
    end
  end

  // Next-state logic: qualify a level change for DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d       = state;
    cnt_d         = cnt;
    press_evt_d   = 1'b0;
    release_evt_d = 1'b0;
    unique case (state)
      RELEASED: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          press_evt_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d       = RELEASED;
          cnt_d         = '0;
          release_evt_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: the level follows the debounced state, pulses follow the
  // one-shot flags set on the qualifying transition.
  always_comb begin
    pressed_d = (state == PRESSED) || (state == RELEASE_WAIT);
    press_d   = press_evt;
    release_d = release_evt;
  end

  // Output register: glitch-free level and pulses, aligned to the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed_o <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      pressed_o <= pressed_d;
      press_o   <= press_d;
      release_o <= release_d;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BUTTONS raw button pins into clean active-high levels plus
// one-cycle press/release pulses; one independent channel per button.
module button_debounce
  import example_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(10),
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button_i,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o
);

  // One fully independent channel per button pin.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin       (button_i[i]),
      .pressed_o (pressed_o[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES=8, active-low pins).
// Stimulus tasks push expected pulse events with their due cycle; a negedge
// monitor pops and compares them and checks for unexpected pulses and level.
module tb_button_debounce;

  localparam int NB  = 3;
  localparam int DC  = 8;
  localparam int LAT = DC + 2;

  typedef struct {
    int          cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] button_i;
  logic [NB-1:0] pressed_o, press_o, release_o;

  ev_t           sb[$];
  logic [NB-1:0] exp_level = '0;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            mon_en = 1'b0;

  button_debounce #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .button_i  (button_i),
    .pressed_o (pressed_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [NB-1:0] exp_p, exp_r;
    if (mon_en) begin
      exp_p = '0;
      exp_r = '0;
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        miscompares++;
        $display("FAIL missed_event: due cycle %0d not seen (now %0d) press=%b release=%b",
                 sb[0].cyc, cyc, sb[0].press, sb[0].rel);
        exp_level = (exp_level | sb[0].press) & ~sb[0].rel;
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        exp_p     = sb[0].press;
        exp_r     = sb[0].rel;
        exp_level = (exp_level | exp_p) & ~exp_r;
        void'(sb.pop_front());
      end
      vectors++;
      if ({pressed_o, press_o, release_o} !== {exp_level, exp_p, exp_r}) begin
        miscompares++;
        $display("FAIL cycle_%0d: got pressed=%b press=%b release=%b, want pressed=%b press=%b release=%b",
                 cyc, pressed_o, press_o, release_o, exp_level, exp_p, exp_r);
      end
      assert ((press_o & release_o) == '0)
        else $error("FAIL overlap: press=%b release=%b at cycle %0d", press_o, release_o, cyc);
    end
  end

  // Advance to just after the next falling edge; inputs change here.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Queue an event due LAT edges after the next sampling edge.
  task automatic expect_ev(input logic [NB-1:0] p, input logic [NB-1:0] r);
    ev_t e;
    e.cyc   = cyc + 1 + LAT;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
  endtask

  // Wait (bounded) for all queued events to be observed, then idle a little.
  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d events still pending, want 0", name, sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    button_i = 3'b000;
    #1;
    vectors++;
    if ({pressed_o, press_o, release_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b %b %b, want 000 000 000", pressed_o, press_o, release_o);
    end
    mon_en = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    expect_ev(3'b111, 3'b000);
    wait_drain("reset_release");
  endtask

  task automatic test_clean();
    button_i[0] = 1'b1;
    expect_ev(3'b000, 3'b001);
    wait_drain("clean_release");
    button_i[0] = 1'b0;
    expect_ev(3'b001, 3'b000);
    wait_drain("clean_press");
    button_i[2:1] = 2'b11;
    expect_ev(3'b000, 3'b110);
    wait_drain("release_12");
  endtask

  task automatic test_bounce();
    button_i[1] = 1'b0;
    repeat (5) step();
    button_i[1] = 1'b1;
    repeat (15) step();
    vectors++;
    if (pressed_o[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_reject: pressed_o[1]=%b, want 0", pressed_o[1]);
    end
    button_i[1] = 1'b0;
    repeat (3) step();
    button_i[1] = 1'b1;
    step();
    button_i[1] = 1'b0;
    expect_ev(3'b010, 3'b000);
    wait_drain("bounce_press");
  endtask

  // Exactly DC-1 stable samples are rejected, exactly DC samples qualify.
  task automatic test_boundary();
    button_i[2] = 1'b0;
    repeat (DC - 1) step();
    button_i[2] = 1'b1;
    repeat (12) step();
    button_i[2] = 1'b0;
    expect_ev(3'b100, 3'b000);
    repeat (DC) step();
    button_i[2] = 1'b1;
    expect_ev(3'b000, 3'b100);
    wait_drain("boundary");
  endtask

  task automatic test_simultaneous();
    button_i[0] = 1'b1;
    button_i[2] = 1'b0;
    expect_ev(3'b100, 3'b001);
    wait_drain("simul_a");
    button_i[0] = 1'b0;
    button_i[2] = 1'b1;
    expect_ev(3'b001, 3'b100);
    wait_drain("simul_b");
  endtask

  task automatic test_reset_mid();
    button_i[2] = 1'b0;
    repeat (6) step();
    reset_n   = 1'b0;
    exp_level = '0;
    sb.delete();
    #1;
    vectors++;
    if ({pressed_o, press_o, release_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b %b %b, want 000 000 000", pressed_o, press_o, release_o);
    end
    repeat (3) step();
    reset_n = 1'b1;
    expect_ev(3'b111, 3'b000);
    wait_drain("requalify");
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 4; i++) begin
      step();
      button_i[i % NB] = 1'b1;
      #1;
      button_i[i % NB] = 1'b0;
    end
    repeat (2 * LAT) step();
    vectors++;
    if (pressed_o !== 3'b111) begin
      miscompares++;
      $display("FAIL glitch_level: pressed_o=%b, want 111", pressed_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_boundary();
    test_simultaneous();
    test_reset_mid();
    test_glitch();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
